cpu_regfile_mp: RTL

Parametrised multi-port CPU register file that replaces the single-port 8x8 primary register block.
- Two asynchronous read ports for operand fetch and one synchronous write port for writeback.
- Per-register busy scoreboard for hazard detection.
- Bus-export FSM drives a stable register snapshot onto the shared data bus under a req/ack handshake.
- Sits between decode/execute and the system data bus. All bus signals are split into dout/oe; there is no internal tri-state.

---
 rtl/cpu_regfile_pkg.sv | 14 +
 rtl/cpu_regfile_bus_if.sv | 58 +++++
 rtl/cpu_regfile_mp.sv | 118 +++++++++++
 3 files changed

// File: rtl/cpu_regfile_pkg.sv
// Shared types and default sizes for the multi-port register file.
// The optional REGFILE_BYPASS_EN macro enables same-cycle write forwarding.
package cpu_regfile_pkg;

    localparam int DEF_DATA_W   = 8;
    localparam int DEF_NUM_REGS = 8;

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        DONE
    } bus_state_e;

endpackage

// File: rtl/cpu_regfile_bus_if.sv
// Bus export engine: snapshots one register and holds it on the bus until acked.
// Fed by the register file's third read port (forwarded when REGFILE_BYPASS_EN).
import cpu_regfile_pkg::*;

module cpu_regfile_bus_if #(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              bus_req,
    input  logic [DATA_W-1:0] rd_data,
    input  logic              bus_ack,
    output logic [DATA_W-1:0] bus_dout,
    output logic              bus_oe,
    output logic              bus_done
);

    bus_state_e        state;
    bus_state_e        state_nx;
    logic [DATA_W-1:0] snap;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            snap  <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && bus_req)
                snap <= rd_data;
        end
    end

    // Outputs decode from state only so reset drops oe without waiting for a clock
    always_comb begin
        state_nx = state;
        bus_oe   = 1'b0;
        bus_done = 1'b0;
        bus_dout = '0;
        unique case (state)
            IDLE: begin
                if (bus_req)
                    state_nx = DRIVE;
            end
            DRIVE: begin
                bus_oe   = 1'b1;
                bus_dout = snap;
                if (bus_ack)
                    state_nx = DONE;
            end
            DONE: begin
                bus_done = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule

// File: rtl/cpu_regfile_mp.sv
// Multi-port register file: two async reads, one write, busy scoreboard, bus export.
// Define REGFILE_BYPASS_EN to forward writeback data to the read ports.
import cpu_regfile_pkg::*;

module cpu_regfile_mp #(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int ADDR_W   = $clog2(NUM_REGS)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [ADDR_W-1:0]   ra_addr,
    output logic [DATA_W-1:0]   ra_data,
    output logic                ra_busy,
    input  logic [ADDR_W-1:0]   rb_addr,
    output logic [DATA_W-1:0]   rb_data,
    output logic                rb_busy,
    input  logic                wr_en,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic [DATA_W-1:0]   wr_data,
    input  logic                claim_en,
    input  logic [ADDR_W-1:0]   claim_addr,
    output logic [NUM_REGS-1:0] busy,
    input  logic                bus_req,
    input  logic [ADDR_W-1:0]   bus_addr,
    input  logic                bus_ack,
    output logic [DATA_W-1:0]   bus_dout,
    output logic                bus_oe,
    output logic                bus_done
);

    localparam logic [ADDR_W:0] NREGS = NUM_REGS[ADDR_W:0];

    logic [DATA_W-1:0] regs [NUM_REGS];
    logic [DATA_W-1:0] bus_rd;
    logic              wr_ok;
    logic              claim_ok;

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return {1'b0, a} < NREGS;
    endfunction

    function automatic logic fwd(input logic [ADDR_W-1:0] a);
`ifdef REGFILE_BYPASS_EN
        return wr_ok && (wr_addr == a);
`else
        return (a != a);
`endif
    endfunction

    assign wr_ok    = wr_en && in_range(wr_addr);
    assign claim_ok = claim_en && in_range(claim_addr);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++)
                regs[i] <= '0;
        end else if (wr_ok) begin
            regs[wr_addr] <= wr_data;
        end
    end

    // Claim is applied last so a same-index claim overrides the clear
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy <= '0;
        end else begin
            if (wr_ok)
                busy[wr_addr] <= 1'b0;
            if (claim_ok)
                busy[claim_addr] <= 1'b1;
        end
    end

    always_comb begin
        ra_data = '0;
        ra_busy = 1'b0;
        if (fwd(ra_addr)) begin
            ra_data = wr_data;
        end else if (in_range(ra_addr)) begin
            ra_data = regs[ra_addr];
            ra_busy = busy[ra_addr];
        end
    end

    always_comb begin
        rb_data = '0;
        rb_busy = 1'b0;
        if (fwd(rb_addr)) begin
            rb_data = wr_data;
        end else if (in_range(rb_addr)) begin
            rb_data = regs[rb_addr];
            rb_busy = busy[rb_addr];
        end
    end

    always_comb begin
        bus_rd = '0;
        if (fwd(bus_addr))
            bus_rd = wr_data;
        else if (in_range(bus_addr))
            bus_rd = regs[bus_addr];
    end

    cpu_regfile_bus_if #(
        .DATA_W(DATA_W)
    ) u_bus_if (
        .clk     (clk),
        .reset   (reset),
        .bus_req (bus_req),
        .rd_data (bus_rd),
        .bus_ack (bus_ack),
        .bus_dout(bus_dout),
        .bus_oe  (bus_oe),
        .bus_done(bus_done)
    );

endmodule
